// File: rtl/execute_stage_mc_if.sv
// EX stage bus: decode-side request, forwarding inputs and EX/MEM output.
// The master drives requests and out_ready; the slave is the EX stage.
interface execute_stage_mc_if #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [XLEN-1:0]         pc;
    logic [XLEN-1:0]         reg_a;
    logic [XLEN-1:0]         reg_b;
    logic [XLEN-1:0]         imm;
    logic [3:0]              alu_op;
    logic [2:0]              funct3;
    logic                    is_jump;
    logic                    jump_conditional;
    logic                    is_muldiv;
    logic                    a_sel;
    logic                    b_sel;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic                    reg_we;
    logic [NUM_FWD*XLEN-1:0] fwd_data;
    logic [NUM_FWD*5-1:0]    fwd_rd;
    logic [NUM_FWD-1:0]      fwd_we;
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         out_result;
    logic                    out_jump;
    logic                    out_reg_we;
    logic [4:0]              out_rd;

    modport master (
        output in_valid, pc, reg_a, reg_b, imm, alu_op, funct3,
        output is_jump, jump_conditional, is_muldiv, a_sel, b_sel,
        output rs1, rs2, rd, reg_we, fwd_data, fwd_rd, fwd_we, out_ready,
        input  in_ready, out_valid, out_result, out_jump, out_reg_we, out_rd
    );

    modport slave (
        input  in_valid, pc, reg_a, reg_b, imm, alu_op, funct3,
        input  is_jump, jump_conditional, is_muldiv, a_sel, b_sel,
        input  rs1, rs2, rd, reg_we, fwd_data, fwd_rd, fwd_we, out_ready,
        output in_ready, out_valid, out_result, out_jump, out_reg_we, out_rd
    );
endinterface

// File: rtl/execute_stage_mc.sv
// EX stage: forwarding, ALU/branch, EX/MEM register, optional iterative
// mul/div unit enabled by defining EXEC_MULDIV_EN.
module execute_stage_mc #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input logic              clk,
    input logic              rst_n,
    execute_stage_mc_if.slave bus
);
    localparam int SW = $clog2(XLEN);

    // alu_op: 0 add 1 sub 2 sll 3 slt 4 sltu 5 xor 6 srl 7 sra 8 or 9 and 10 passb
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASB = 4'd10;

    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_res;
    logic [SW-1:0]   shamt;
    logic            take, jump, free, accept, alu_load;
    logic            md_load, md_we;
    logic [4:0]      md_rd;
    logic [XLEN-1:0] md_res;

    logic            out_valid_q, out_jump_q, out_we_q;
    logic [XLEN-1:0] out_result_q;
    logic [4:0]      out_rd_q;

    // Lowest index is the youngest producer, so it is applied last.
    always_comb begin
        fwd_a = bus.reg_a;
        fwd_b = bus.reg_b;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (bus.fwd_we[i] && bus.fwd_rd[i*5 +: 5] == bus.rs1 && bus.rs1 != 5'd0)
                fwd_a = bus.fwd_data[i*XLEN +: XLEN];
            if (bus.fwd_we[i] && bus.fwd_rd[i*5 +: 5] == bus.rs2 && bus.rs2 != 5'd0)
                fwd_b = bus.fwd_data[i*XLEN +: XLEN];
        end
    end

    assign op_a  = bus.a_sel ? fwd_a : bus.pc;
    assign op_b  = bus.b_sel ? bus.imm : fwd_b;
    assign shamt = op_b[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (bus.alu_op)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_PASB: alu_res = op_b;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        take = 1'b0;
        case (bus.funct3)
            3'b000:  take = fwd_a == fwd_b;
            3'b001:  take = fwd_a != fwd_b;
            3'b100:  take = $signed(fwd_a) < $signed(fwd_b);
            3'b101:  take = $signed(fwd_a) >= $signed(fwd_b);
            3'b110:  take = fwd_a < fwd_b;
            3'b111:  take = fwd_a >= fwd_b;
            default: take = 1'b0;
        endcase
    end

    assign jump   = bus.is_jump & (~bus.jump_conditional | take);
    assign free   = ~out_valid_q | bus.out_ready;
    assign accept = bus.in_valid & bus.in_ready;

`ifdef EXEC_MULDIV_EN
    localparam logic [SW-1:0] LAST = SW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, MD_RUN, MD_DONE} state_t;
    state_t state_q, state_d;

    logic              md_start, sa, sb, neg_a, neg_b;
    logic [SW-1:0]     cnt_q;
    logic [2:0]        f3_q;
    logic              neg_a_q, neg_b_q, dz_q, we_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   hi_q, lo_q, opnd_q, orig_a_q;
    logic [XLEN-1:0]   mag_a, mag_b, div_sub, quo_s, rem_s;
    logic [XLEN:0]     mul_sum, div_ext;
    logic              div_ge;
    logic [2*XLEN-1:0] prod, prod_s;

    assign bus.in_ready = rst_n & (state_q == IDLE) & free;
    assign alu_load     = accept & ~bus.is_muldiv;
    assign md_rd        = rd_q;
    assign md_we        = we_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        md_start = 1'b0;
        md_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && bus.is_muldiv) begin
                    md_start = 1'b1;
                    state_d  = MD_RUN;
                end
            end
            MD_RUN: begin
                if (cnt_q == LAST) state_d = MD_DONE;
            end
            MD_DONE: begin
                if (free) begin
                    md_load = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Signedness per funct3: mul 000/001 s*s, 010 s*u, 011 u*u; div even=signed.
    assign sa    = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    assign sb    = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    assign neg_a = sa & fwd_a[XLEN-1];
    assign neg_b = sb & fwd_b[XLEN-1];
    assign mag_a = neg_a ? -fwd_a : fwd_a;
    assign mag_b = neg_b ? -fwd_b : fwd_b;

    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_ext = {hi_q, lo_q[XLEN-1]};
    assign div_ge  = div_ext >= {1'b0, opnd_q};
    assign div_sub = div_ext[XLEN-1:0] - opnd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            we_q     <= 1'b0;
            rd_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            orig_a_q <= '0;
        end else if (md_start) begin
            cnt_q    <= '0;
            f3_q     <= bus.funct3;
            neg_a_q  <= neg_a;
            neg_b_q  <= neg_b;
            dz_q     <= fwd_b == '0;
            we_q     <= bus.reg_we;
            rd_q     <= bus.rd;
            hi_q     <= '0;
            lo_q     <= bus.funct3[2] ? mag_a : mag_b;
            opnd_q   <= bus.funct3[2] ? mag_b : mag_a;
            orig_a_q <= fwd_a;
        end else if (state_q == MD_RUN) begin
            cnt_q <= cnt_q + 1'b1;
            if (!f3_q[2]) begin
                hi_q <= mul_sum[XLEN:1];
                lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
            end else if (div_ge) begin
                hi_q <= div_sub;
                lo_q <= {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_q <= div_ext[XLEN-1:0];
                lo_q <= {lo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign prod   = {hi_q, lo_q};
    assign prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
    assign quo_s  = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
    assign rem_s  = neg_a_q ? -hi_q : hi_q;

    always_comb begin
        md_res = '0;
        case (f3_q)
            3'b000:         md_res = prod_s[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         md_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101: md_res = dz_q ? '1 : quo_s;
            default:        md_res = dz_q ? orig_a_q : rem_s;
        endcase
    end
`else
    logic unused_md;

    assign bus.in_ready = rst_n & free;
    assign alu_load     = accept;
    assign md_load      = 1'b0;
    assign md_rd        = '0;
    assign md_we        = 1'b0;
    assign md_res       = '0;
    assign unused_md    = bus.is_muldiv;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_jump_q   <= 1'b0;
            out_we_q     <= 1'b0;
            out_rd_q     <= '0;
        end else if (alu_load) begin
            out_valid_q  <= 1'b1;
            out_result_q <= alu_res;
            out_jump_q   <= jump;
            out_we_q     <= bus.reg_we;
            out_rd_q     <= bus.rd;
        end else if (md_load) begin
            out_valid_q  <= 1'b1;
            out_result_q <= md_res;
            out_jump_q   <= 1'b0;
            out_we_q     <= md_we;
            out_rd_q     <= md_rd;
        end else if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_jump   = out_jump_q;
    assign bus.out_reg_we = out_we_q;
    assign bus.out_rd     = out_rd_q;
endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc: reset, ALU, forwarding, branches,
// backpressure, back-to-back and (with EXEC_MULDIV_EN) mul/div.
module tb_execute_stage_mc;
    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    execute_stage_mc_if #(.XLEN(32), .NUM_FWD(2)) bus ();

    execute_stage_mc #(.XLEN(32), .NUM_FWD(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.in_valid         = 1'b0;
        bus.pc               = '0;
        bus.reg_a            = '0;
        bus.reg_b            = '0;
        bus.imm              = '0;
        bus.alu_op           = 4'd0;
        bus.funct3           = 3'd0;
        bus.is_jump          = 1'b0;
        bus.jump_conditional = 1'b0;
        bus.is_muldiv        = 1'b0;
        bus.a_sel            = 1'b1;
        bus.b_sel            = 1'b0;
        bus.rs1              = 5'd1;
        bus.rs2              = 5'd2;
        bus.rd               = 5'd3;
        bus.reg_we           = 1'b1;
        bus.fwd_data         = '0;
        bus.fwd_rd           = '0;
        bus.fwd_we           = '0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        clear_in();
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.reg_a    = a;
        bus.reg_b    = b;
        bus.rd       = rd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        clear_in();
        step();
        step();
        vecs++;
        if (bus.out_valid !== 1'b0) begin
            errs++; $display("FAIL reset_valid got %b exp 0", bus.out_valid);
        end
        vecs++;
        if (bus.out_result !== 32'd0) begin
            errs++; $display("FAIL reset_result got %h exp 0", bus.out_result);
        end
        vecs++;
        if (bus.out_rd !== 5'd0) begin
            errs++; $display("FAIL reset_rd got %0d exp 0", bus.out_rd);
        end
        vecs++;
        if (bus.out_jump !== 1'b0 || bus.out_reg_we !== 1'b0) begin
            errs++; $display("FAIL reset_flags got %b%b exp 00", bus.out_jump, bus.out_reg_we);
        end
        vecs++;
        if (bus.in_ready !== 1'b0) begin
            errs++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready);
        end
        rst_n = 1'b1;
        #1;
        vecs++;
        if (bus.in_ready !== 1'b1) begin
            errs++; $display("FAIL post_reset_in_ready got %b exp 1", bus.in_ready);
        end
    endtask

    task automatic test_alu();
        drive(4'd0, 32'd5, 32'd7, 5'd3);
        step();
        bus.in_valid = 1'b0;
        vecs++;
        if (bus.out_valid !== 1'b1) begin
            errs++; $display("FAIL add_valid got %b exp 1", bus.out_valid);
        end
        vecs++;
        if (bus.out_result !== 32'd12) begin
            errs++; $display("FAIL add_result got %h exp %h", bus.out_result, 32'd12);
        end
        vecs++;
        if (bus.out_rd !== 5'd3 || bus.out_reg_we !== 1'b1 || bus.out_jump !== 1'b0) begin
            errs++; $display("FAIL add_ctl got rd=%0d we=%b j=%b exp rd=3 we=1 j=0",
                             bus.out_rd, bus.out_reg_we, bus.out_jump);
        end
        drive(4'd0, 32'd0, 32'd0, 5'd4);
        bus.a_sel = 1'b0;
        bus.b_sel = 1'b1;
        bus.pc    = 32'h100;
        bus.imm   = 32'h10;
        step();
        vecs++;
        if (bus.out_result !== 32'h110 || bus.out_rd !== 5'd4) begin
            errs++; $display("FAIL pc_imm got %h rd=%0d exp 00000110 rd=4", bus.out_result, bus.out_rd);
        end
        drive(4'd1, 32'd5, 32'd7, 5'd3);
        step();
        vecs++;
        if (bus.out_result !== 32'hFFFF_FFFE) begin
            errs++; $display("FAIL sub got %h exp fffffffe", bus.out_result);
        end
        drive(4'd7, 32'h8000_0000, 32'd0, 5'd3);
        bus.b_sel = 1'b1;
        bus.imm   = 32'd4;
        step();
        bus.in_valid = 1'b0;
        vecs++;
        if (bus.out_result !== 32'hF800_0000) begin
            errs++; $display("FAIL sra got %h exp f8000000", bus.out_result);
        end
        step();
        vecs++;
        if (bus.out_valid !== 1'b0) begin
            errs++; $display("FAIL idle_valid got %b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_forward();
        drive(4'd0, 32'd9, 32'd0, 5'd3);
        bus.rs1      = 5'd4;
        bus.rs2      = 5'd0;
        bus.fwd_rd   = {5'd4, 5'd4};
        bus.fwd_data = {32'd200, 32'd100};
        bus.fwd_we   = 2'b11;
        step();
        vecs++;
        if (bus.out_result !== 32'd100) begin
            errs++; $display("FAIL fwd_prio got %0d exp 100", bus.out_result);
        end
        bus.fwd_we = 2'b10;
        step();
        vecs++;
        if (bus.out_result !== 32'd200) begin
            errs++; $display("FAIL fwd_src1 got %0d exp 200", bus.out_result);
        end
        bus.rs1    = 5'd0;
        bus.fwd_rd = {5'd0, 5'd0};
        bus.fwd_we = 2'b11;
        step();
        vecs++;
        if (bus.out_result !== 32'd9) begin
            errs++; $display("FAIL fwd_x0 got %0d exp 9", bus.out_result);
        end
        bus.rs1      = 5'd1;
        bus.rs2      = 5'd6;
        bus.fwd_rd   = {5'd0, 5'd6};
        bus.fwd_data = {32'd0, 32'd33};
        bus.fwd_we   = 2'b01;
        step();
        bus.in_valid = 1'b0;
        vecs++;
        if (bus.out_result !== 32'd42) begin
            errs++; $display("FAIL fwd_b got %0d exp 42", bus.out_result);
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3 [5];
        logic [31:0] ra [5];
        logic [31:0] rb [5];
        logic        jc [5];
        logic        exp_j [5];
        f3[0] = 3'b100; ra[0] = 32'hFFFF_FFFF; rb[0] = 32'd1; jc[0] = 1'b1; exp_j[0] = 1'b1;
        f3[1] = 3'b110; ra[1] = 32'hFFFF_FFFF; rb[1] = 32'd1; jc[1] = 1'b1; exp_j[1] = 1'b0;
        f3[2] = 3'b110; ra[2] = 32'hFFFF_FFFF; rb[2] = 32'd1; jc[2] = 1'b0; exp_j[2] = 1'b1;
        f3[3] = 3'b010; ra[3] = 32'd3;         rb[3] = 32'd3; jc[3] = 1'b1; exp_j[3] = 1'b0;
        f3[4] = 3'b000; ra[4] = 32'd5;         rb[4] = 32'd5; jc[4] = 1'b1; exp_j[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(4'd0, ra[i], rb[i], 5'd0);
            bus.is_jump          = 1'b1;
            bus.jump_conditional = jc[i];
            bus.funct3           = f3[i];
            bus.reg_we           = 1'b0;
            step();
            vecs++;
            if (bus.out_jump !== exp_j[i]) begin
                errs++; $display("FAIL branch_%0d got %b exp %b", i, bus.out_jump, exp_j[i]);
            end
        end
        drive(4'd0, 32'd5, 32'd5, 5'd0);
        bus.is_jump          = 1'b1;
        bus.jump_conditional = 1'b1;
        bus.funct3           = 3'b001;
        bus.b_sel            = 1'b1;
        bus.imm              = 32'd5;
        bus.fwd_rd           = {5'd0, 5'd2};
        bus.fwd_data         = {32'd0, 32'd6};
        bus.fwd_we           = 2'b01;
        step();
        bus.in_valid = 1'b0;
        vecs++;
        if (bus.out_jump !== 1'b1) begin
            errs++; $display("FAIL bne_fwd got %b exp 1", bus.out_jump);
        end
        step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(4'd0, 32'd5, 32'd7, 5'd3);
        step();
        drive(4'd0, 32'd1, 32'd1, 5'd5);
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd12 || bus.out_rd !== 5'd3) begin
                errs++; $display("FAIL hold_%0d got v=%b r=%h rd=%0d exp v=1 r=0000000c rd=3",
                                 i, bus.out_valid, bus.out_result, bus.out_rd);
            end
            vecs++;
            if (bus.in_ready !== 1'b0) begin
                errs++; $display("FAIL hold_ready_%0d got %b exp 0", i, bus.in_ready);
            end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        vecs++;
        if (bus.in_ready !== 1'b1) begin
            errs++; $display("FAIL release_ready got %b exp 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd2 || bus.out_rd !== 5'd5) begin
            errs++; $display("FAIL after_release got v=%b r=%h rd=%0d exp v=1 r=00000002 rd=5",
                             bus.out_valid, bus.out_result, bus.out_rd);
        end
        step();
        vecs++;
        if (bus.out_valid !== 1'b0) begin
            errs++; $display("FAIL drain got %b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive(4'd0, 32'd1, 32'd2, 5'd10);
        step();
        drive(4'd0, 32'd10, 32'd20, 5'd11);
        vecs++;
        if (bus.out_result !== 32'd3 || bus.out_rd !== 5'd10 || bus.in_ready !== 1'b1) begin
            errs++; $display("FAIL b2b_0 got r=%0d rd=%0d rdy=%b exp r=3 rd=10 rdy=1",
                             bus.out_result, bus.out_rd, bus.in_ready);
        end
        step();
        drive(4'd0, 32'd15, 32'd25, 5'd12);
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd30 || bus.out_rd !== 5'd11) begin
            errs++; $display("FAIL b2b_1 got v=%b r=%0d rd=%0d exp v=1 r=30 rd=11",
                             bus.out_valid, bus.out_result, bus.out_rd);
        end
        step();
        bus.in_valid = 1'b0;
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd40 || bus.out_rd !== 5'd12) begin
            errs++; $display("FAIL b2b_2 got v=%b r=%0d rd=%0d exp v=1 r=40 rd=12",
                             bus.out_valid, bus.out_result, bus.out_rd);
        end
        step();
    endtask

`ifdef EXEC_MULDIV_EN
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit rdy_seen);
        clear_in();
        bus.in_valid  = 1'b1;
        bus.is_muldiv = 1'b1;
        bus.funct3    = f3;
        bus.reg_a     = a;
        bus.reg_b     = b;
        bus.rd        = 5'd7;
        step();
        bus.in_valid = 1'b0;
        lat      = 0;
        rdy_seen = 1'b0;
        do begin
            step();
            lat++;
            if (!bus.out_valid && bus.in_ready) rdy_seen = 1'b1;
        end while (!bus.out_valid && lat < 100);
        res = bus.out_result;
        step();
    endtask

    task automatic test_muldiv();
        logic [2:0]  f3 [10];
        logic [31:0] a [10];
        logic [31:0] b [10];
        logic [31:0] e [10];
        logic [31:0] res;
        int          lat;
        bit          rdy;
        f3[0] = 3'b001; a[0] = 32'h8000_0000; b[0] = 32'h8000_0000; e[0] = 32'h4000_0000;
        f3[1] = 3'b000; a[1] = 32'd6;         b[1] = 32'd7;         e[1] = 32'd42;
        f3[2] = 3'b011; a[2] = 32'hFFFF_FFFF; b[2] = 32'hFFFF_FFFF; e[2] = 32'hFFFF_FFFE;
        f3[3] = 3'b010; a[3] = 32'hFFFF_FFFF; b[3] = 32'hFFFF_FFFF; e[3] = 32'hFFFF_FFFF;
        f3[4] = 3'b100; a[4] = 32'd7;         b[4] = 32'd0;         e[4] = 32'hFFFF_FFFF;
        f3[5] = 3'b110; a[5] = 32'd7;         b[5] = 32'd0;         e[5] = 32'd7;
        f3[6] = 3'b100; a[6] = 32'h8000_0000; b[6] = 32'hFFFF_FFFF; e[6] = 32'h8000_0000;
        f3[7] = 3'b110; a[7] = 32'h8000_0000; b[7] = 32'hFFFF_FFFF; e[7] = 32'd0;
        f3[8] = 3'b100; a[8] = 32'hFFFF_FFF9; b[8] = 32'd2;         e[8] = 32'hFFFF_FFFD;
        f3[9] = 3'b110; a[9] = 32'hFFFF_FFF9; b[9] = 32'd2;         e[9] = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            run_md(f3[i], a[i], b[i], res, lat, rdy);
            vecs++;
            if (res !== e[i]) begin
                errs++; $display("FAIL md_%0d f3=%0d got %h exp %h", i, f3[i], res, e[i]);
            end
            if (i == 0) begin
                vecs++;
                if (lat != 33) begin
                    errs++; $display("FAIL md_latency got %0d exp 33", lat);
                end
                vecs++;
                if (rdy) begin
                    errs++; $display("FAIL md_in_ready got 1 during run exp 0");
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        bit seen;
        clear_in();
        bus.in_valid  = 1'b1;
        bus.is_muldiv = 1'b1;
        bus.funct3    = 3'b101;
        bus.reg_a     = 32'd100;
        bus.reg_b     = 32'd7;
        step();
        bus.in_valid = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        vecs++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errs++; $display("FAIL midop_reset got v=%b rdy=%b exp 0 0", bus.out_valid, bus.in_ready);
        end
        step();
        rst_n = 1'b1;
        #1;
        vecs++;
        if (bus.in_ready !== 1'b1) begin
            errs++; $display("FAIL midop_idle got rdy=%b exp 1", bus.in_ready);
        end
        seen = 1'b0;
        repeat (40) begin
            step();
            if (bus.out_valid) seen = 1'b1;
        end
        vecs++;
        if (seen) begin
            errs++; $display("FAIL midop_nowrite got out_valid=1 exp 0");
        end
    endtask
`else
    task automatic test_muldiv_disabled();
        drive(4'd0, 32'd5, 32'd7, 5'd8);
        bus.is_muldiv = 1'b1;
        bus.funct3    = 3'b100;
        step();
        bus.in_valid = 1'b0;
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd12 || bus.out_rd !== 5'd8) begin
            errs++; $display("FAIL md_as_alu got v=%b r=%h rd=%0d exp v=1 r=0000000c rd=8",
                             bus.out_valid, bus.out_result, bus.out_rd);
        end
        step();
    endtask
`endif

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_alu();
        test_forward();
        test_branch();
        test_backpressure();
        test_back_to_back();
`ifdef EXEC_MULDIV_EN
        test_muldiv();
        test_reset_midop();
`else
        test_muldiv_disabled();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
